// File: rtl/addr_decode_pkg.sv
// Shared definitions for the banked address decoder: attribute bit layout,
// the PET default map entry type and the function that produces it.
package addr_decode_pkg;

  localparam int DEV_RAM   = 0;
  localparam int DEV_MAGIC = 1;
  localparam int DEV_PIA1  = 2;
  localparam int DEV_PIA2  = 3;
  localparam int DEV_VIA   = 4;
  localparam int DEV_CRTC  = 5;

  // Flag positions counted upward from the first bit above the device field.
  localparam int ATTR_IO_OFS  = 0;
  localparam int ATTR_RO_OFS  = 1;
  localparam int ATTR_MIR_OFS = 2;

  localparam int PET_AW = 17;

  typedef struct packed {
    logic              en;
    logic [PET_AW-1:0] base;
    logic [PET_AW-1:0] mask;
    logic [2:0]        dev;
    logic              io;
    logic              ro;
    logic              mir;
  } pet_entry_t;

  function automatic pet_entry_t pet_default(input int idx);
    pet_entry_t e;
    e    = '0;
    e.en = 1'b1;
    case (idx)
      0: begin e.base = 17'h00000; e.mask = 17'h18000; e.dev = 3'(DEV_RAM); end
      1: begin e.base = 17'h08000; e.mask = 17'h1F000; e.dev = 3'(DEV_RAM); e.mir = 1'b1; end
      2: begin e.base = 17'h0E800; e.mask = 17'h1FFF0; e.dev = 3'(DEV_MAGIC); end
      3: begin e.base = 17'h0E810; e.mask = 17'h1FFF0; e.dev = 3'(DEV_PIA1); e.io = 1'b1; end
      4: begin e.base = 17'h0E820; e.mask = 17'h1FFE0; e.dev = 3'(DEV_PIA2); e.io = 1'b1; end
      5: begin e.base = 17'h0E840; e.mask = 17'h1FFC0; e.dev = 3'(DEV_VIA);  e.io = 1'b1; end
      6: begin e.base = 17'h0E880; e.mask = 17'h1FF80; e.dev = 3'(DEV_CRTC); e.io = 1'b1; end
      default: e.en = 1'b0;
    endcase
    return e;
  endfunction

endpackage

// File: rtl/region_match.sv
// Combinational comparator bank with a lowest-index-wins priority encoder.
// Falls back to the supplied default attribute when no enabled entry matches.
module region_match #(
  parameter int ADDR_WIDTH  = 17,
  parameter int NUM_REGIONS = 8,
  parameter int ATTR_W      = 9,
  parameter int IDX_W       = 3
) (
  input  logic [ADDR_WIDTH-1:0]  addr_i,
  input  logic [NUM_REGIONS-1:0] en_i,
  input  logic [ADDR_WIDTH-1:0]  base_i [NUM_REGIONS],
  input  logic [ADDR_WIDTH-1:0]  mask_i [NUM_REGIONS],
  input  logic [ATTR_W-1:0]      attr_i [NUM_REGIONS],
  input  logic [ATTR_W-1:0]      default_attr_i,
  output logic                   hit_o,
  output logic [IDX_W-1:0]       hit_index_o,
  output logic [ATTR_W-1:0]      attr_o
);

  logic [NUM_REGIONS-1:0] match;

  always_comb begin
    match = '0;
    for (int i = 0; i < NUM_REGIONS; i++) begin
      match[i] = en_i[i] && ((addr_i & mask_i[i]) == (base_i[i] & mask_i[i]));
    end
  end

  // Scan from the top down so the lowest matching index is the last writer.
  always_comb begin
    hit_o       = 1'b0;
    hit_index_o = '0;
    attr_o      = default_attr_i;
    for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
      if (match[i]) begin
        hit_o       = 1'b1;
        hit_index_o = IDX_W'(i);
        attr_o      = attr_i[i];
      end
    end
  end

endmodule

// File: rtl/banked_address_decoder.sv
// Reprogrammable memory-map decoder: double-buffered region table, registered
// lowest-index-wins decode and sticky write-protect fault capture.
module banked_address_decoder
  import addr_decode_pkg::*;
#(
  parameter int ADDR_WIDTH  = 17,
  parameter int NUM_REGIONS = 8,
  parameter int NUM_DEVICES = 6,
  parameter logic [NUM_DEVICES+2:0] DEFAULT_ATTR =
    (NUM_DEVICES+3)'(1) | ((NUM_DEVICES+3)'(1) << (NUM_DEVICES + ATTR_RO_OFS))
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic [ADDR_WIDTH-1:0]          addr,
  input  logic                           addr_valid,
  input  logic                           addr_we,
  input  logic                           cfg_we,
  input  logic [$clog2(NUM_REGIONS)-1:0] cfg_index,
  input  logic [ADDR_WIDTH-1:0]          cfg_base,
  input  logic [ADDR_WIDTH-1:0]          cfg_mask,
  input  logic [NUM_DEVICES+2:0]         cfg_attr,
  input  logic                           cfg_en,
  input  logic                           cfg_commit,
  input  logic                           fault_clear,
  output logic                           dec_valid,
  output logic [NUM_DEVICES-1:0]         dev_enable,
  output logic                           is_io,
  output logic                           is_readonly,
  output logic                           is_mirrored,
  output logic                           hit,
  output logic [$clog2(NUM_REGIONS)-1:0] hit_index,
  output logic                           wp_fault,
  output logic [ADDR_WIDTH-1:0]          wp_fault_addr,
  output logic [7:0]                     wp_fault_count
);

  localparam int ATTR_W = NUM_DEVICES + 3;
  localparam int IDX_W  = $clog2(NUM_REGIONS);

  typedef struct packed {
    logic                  en;
    logic [ADDR_WIDTH-1:0] base;
    logic [ADDR_WIDTH-1:0] mask;
    logic [ATTR_W-1:0]     attr;
  } region_t;

  // Widen a 17-bit PET entry: base zero-extended, mask one-extended.
  function automatic region_t expand(input pet_entry_t p);
    region_t r;
    r      = '0;
    r.en   = p.en;
    r.base = ADDR_WIDTH'(p.base);
    if (p.en) begin
      r.mask                              = ~ADDR_WIDTH'(~p.mask);
      r.attr[int'(p.dev)]                 = 1'b1;
      r.attr[NUM_DEVICES + ATTR_IO_OFS]   = p.io;
      r.attr[NUM_DEVICES + ATTR_RO_OFS]   = p.ro;
      r.attr[NUM_DEVICES + ATTR_MIR_OFS]  = p.mir;
    end
    return r;
  endfunction

  region_t shadow_q [NUM_REGIONS];
  region_t shadow_d [NUM_REGIONS];
  region_t active_q [NUM_REGIONS];
  region_t active_d [NUM_REGIONS];
  region_t cfg_entry;

  logic [NUM_REGIONS-1:0] act_en;
  logic [ADDR_WIDTH-1:0]  act_base [NUM_REGIONS];
  logic [ADDR_WIDTH-1:0]  act_mask [NUM_REGIONS];
  logic [ATTR_W-1:0]      act_attr [NUM_REGIONS];

  logic              match_hit;
  logic [IDX_W-1:0]  match_index;
  logic [ATTR_W-1:0] match_attr;

  logic                  dec_valid_q, hit_q;
  logic [IDX_W-1:0]      hit_index_q;
  logic [ATTR_W-1:0]     attr_q;
  logic                  fault_q, fault_d;
  logic [ADDR_WIDTH-1:0] fault_addr_q, fault_addr_d;
  logic [7:0]            fault_cnt_q, fault_cnt_d;
  logic                  wp_event;

  assign cfg_entry = '{en: cfg_en, base: cfg_base, mask: cfg_mask, attr: cfg_attr};

  // Commit copies the post-write shadow so a same-cycle write is included.
  always_comb begin
    shadow_d = shadow_q;
    for (int i = 0; i < NUM_REGIONS; i++) begin
      if (cfg_we && (cfg_index == IDX_W'(i))) shadow_d[i] = cfg_entry;
    end
    active_d = cfg_commit ? shadow_d : active_q;
  end

  always_comb begin
    act_en = '0;
    for (int i = 0; i < NUM_REGIONS; i++) begin
      act_en[i]   = active_q[i].en;
      act_base[i] = active_q[i].base;
      act_mask[i] = active_q[i].mask;
      act_attr[i] = active_q[i].attr;
    end
  end

  region_match #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .NUM_REGIONS(NUM_REGIONS),
    .ATTR_W     (ATTR_W),
    .IDX_W      (IDX_W)
  ) u_match (
    .addr_i        (addr),
    .en_i          (act_en),
    .base_i        (act_base),
    .mask_i        (act_mask),
    .attr_i        (act_attr),
    .default_attr_i(DEFAULT_ATTR),
    .hit_o         (match_hit),
    .hit_index_o   (match_index),
    .attr_o        (match_attr)
  );

  // addr_valid only qualifies the access: decode runs every cycle, and only
  // a qualified write to a readonly target counts as a fault.
  assign wp_event = addr_valid && addr_we && match_attr[NUM_DEVICES + ATTR_RO_OFS];

  always_comb begin
    fault_d      = fault_q;
    fault_addr_d = fault_addr_q;
    fault_cnt_d  = fault_cnt_q;
    if (wp_event) begin
      fault_d = 1'b1;
      if (!fault_q || fault_clear) fault_addr_d = addr;
      if (fault_clear)                fault_cnt_d = 8'd1;
      else if (fault_cnt_q != 8'hFF)  fault_cnt_d = fault_cnt_q + 8'd1;
    end else if (fault_clear) begin
      fault_d      = 1'b0;
      fault_addr_d = '0;
      fault_cnt_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REGIONS; i++) begin
        shadow_q[i] <= expand(pet_default(i));
        active_q[i] <= expand(pet_default(i));
      end
      dec_valid_q  <= 1'b0;
      hit_q        <= 1'b0;
      hit_index_q  <= '0;
      attr_q       <= '0;
      fault_q      <= 1'b0;
      fault_addr_q <= '0;
      fault_cnt_q  <= '0;
    end else begin
      shadow_q     <= shadow_d;
      active_q     <= active_d;
      dec_valid_q  <= addr_valid;
      hit_q        <= match_hit;
      hit_index_q  <= match_index;
      attr_q       <= match_attr;
      fault_q      <= fault_d;
      fault_addr_q <= fault_addr_d;
      fault_cnt_q  <= fault_cnt_d;
    end
  end

  assign dec_valid      = dec_valid_q;
  assign dev_enable     = attr_q[NUM_DEVICES-1:0];
  assign is_io          = attr_q[NUM_DEVICES + ATTR_IO_OFS];
  assign is_readonly    = attr_q[NUM_DEVICES + ATTR_RO_OFS];
  assign is_mirrored    = attr_q[NUM_DEVICES + ATTR_MIR_OFS];
  assign hit            = hit_q;
  assign hit_index      = hit_index_q;
  assign wp_fault       = fault_q;
  assign wp_fault_addr  = fault_addr_q;
  assign wp_fault_count = fault_cnt_q;

endmodule

// File: tb/tb_banked_address_decoder.sv
// Directed bench for banked_address_decoder: default-map vector table plus
// hand-written sequences for commit, priority, write-protect and reset.
module tb_banked_address_decoder;

  logic        clk, reset_n;
  logic [16:0] addr;
  logic        addr_valid, addr_we;
  logic        cfg_we;
  logic [2:0]  cfg_index;
  logic [16:0] cfg_base, cfg_mask;
  logic [8:0]  cfg_attr;
  logic        cfg_en, cfg_commit, fault_clear;
  logic        dec_valid;
  logic [5:0]  dev_enable;
  logic        is_io, is_readonly, is_mirrored, hit;
  logic [2:0]  hit_index;
  logic        wp_fault;
  logic [16:0] wp_fault_addr;
  logic [7:0]  wp_fault_count;

  int n_vec = 0;
  int n_err = 0;

  banked_address_decoder dut (
    .clk(clk), .reset_n(reset_n), .addr(addr), .addr_valid(addr_valid),
    .addr_we(addr_we), .cfg_we(cfg_we), .cfg_index(cfg_index),
    .cfg_base(cfg_base), .cfg_mask(cfg_mask), .cfg_attr(cfg_attr),
    .cfg_en(cfg_en), .cfg_commit(cfg_commit), .fault_clear(fault_clear),
    .dec_valid(dec_valid), .dev_enable(dev_enable), .is_io(is_io),
    .is_readonly(is_readonly), .is_mirrored(is_mirrored), .hit(hit),
    .hit_index(hit_index), .wp_fault(wp_fault), .wp_fault_addr(wp_fault_addr),
    .wp_fault_count(wp_fault_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [16:0] addr;
    logic [5:0]  dev;
    logic        io, ro, mir, hit;
    logic [2:0]  idx;
  } vec_t;

  vec_t vecs [9];

  function automatic logic [8:0] mk_attr(input logic [5:0] dev, input logic io,
                                         input logic ro, input logic mir);
    return {mir, ro, io, dev};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_dec(input string name, input logic [5:0] dev, input logic io,
                         input logic ro, input logic mir, input logic h,
                         input logic [2:0] idx);
    chk(name, {51'd0, dec_valid, dev_enable, is_io, is_readonly, is_mirrored, hit, hit_index},
              {51'd0, 1'b1, dev, io, ro, mir, h, idx});
  endtask

  task automatic chk_miss(input string name);
    chk_dec(name, 6'b000001, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0);
  endtask

  task automatic chk_fault(input string name, input logic f, input logic [16:0] fa,
                           input logic [7:0] cnt);
    chk(name, {38'd0, wp_fault, wp_fault_addr, wp_fault_count}, {38'd0, f, fa, cnt});
  endtask

  task automatic chk_all_zero(input string name);
    chk(name, {24'd0, dec_valid, dev_enable, is_io, is_readonly, is_mirrored, hit, hit_index,
               wp_fault, wp_fault_addr, wp_fault_count}, 64'd0);
  endtask

  task automatic drive_addr(input logic [16:0] a, input logic we);
    @(negedge clk);
    addr = a; addr_valid = 1'b1; addr_we = we;
  endtask

  task automatic set_cfg(input logic [2:0] idx, input logic [16:0] b, input logic [16:0] m,
                         input logic [8:0] at, input logic commit);
    cfg_we = 1'b1; cfg_index = idx; cfg_base = b; cfg_mask = m; cfg_attr = at;
    cfg_en = 1'b1; cfg_commit = commit;
  endtask

  task automatic clr_cfg();
    cfg_we = 1'b0; cfg_commit = 1'b0;
  endtask

  task automatic sample();
    @(posedge clk);
    #1;
  endtask

  logic [16:0] stage_base [4];
  logic [8:0]  stage_attr [4];
  logic [16:0] probe [4];

  initial begin
    reset_n = 1'b0; addr = '0; addr_valid = 1'b0; addr_we = 1'b0;
    cfg_we = 1'b0; cfg_index = '0; cfg_base = '0; cfg_mask = '0; cfg_attr = '0;
    cfg_en = 1'b0; cfg_commit = 1'b0; fault_clear = 1'b0;

    vecs[0] = '{17'h00123, 6'b000001, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0};
    vecs[1] = '{17'h08400, 6'b000001, 1'b0, 1'b0, 1'b1, 1'b1, 3'd1};
    vecs[2] = '{17'h0E815, 6'b000100, 1'b1, 1'b0, 1'b0, 1'b1, 3'd3};
    vecs[3] = '{17'h0E8A0, 6'b100000, 1'b1, 1'b0, 1'b0, 1'b1, 3'd6};
    vecs[4] = '{17'h0C000, 6'b000001, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0};
    vecs[5] = '{17'h0E800, 6'b000010, 1'b0, 1'b0, 1'b0, 1'b1, 3'd2};
    vecs[6] = '{17'h0E83F, 6'b001000, 1'b1, 1'b0, 1'b0, 1'b1, 3'd4};
    vecs[7] = '{17'h0E87F, 6'b010000, 1'b1, 1'b0, 1'b0, 1'b1, 3'd5};
    vecs[8] = '{17'h07FFF, 6'b000001, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0};

    stage_base[0] = 17'h0C000; stage_attr[0] = mk_attr(6'b000100, 1'b0, 1'b0, 1'b0);
    stage_base[1] = 17'h0D000; stage_attr[1] = mk_attr(6'b001000, 1'b1, 1'b0, 1'b0);
    stage_base[2] = 17'h0E000; stage_attr[2] = mk_attr(6'b010000, 1'b0, 1'b1, 1'b0);
    stage_base[3] = 17'h0F000; stage_attr[3] = mk_attr(6'b100000, 1'b0, 1'b0, 1'b1);
    probe[0] = 17'h0C000; probe[1] = 17'h0D000; probe[2] = 17'h0E815; probe[3] = 17'h0F000;

    #12;
    chk_all_zero("reset_outputs");
    @(negedge clk);
    reset_n = 1'b1;

    // Default-map sweep; also confirm outputs hold until the next edge.
    for (int i = 0; i < 9; i++) begin
      drive_addr(vecs[i].addr, 1'b0);
      if (i > 0) begin
        #1;
        chk("latency_hold", {61'd0, hit_index}, {61'd0, vecs[i-1].idx});
      end
      sample();
      chk_dec($sformatf("sweep_%0h", vecs[i].addr), vecs[i].dev, vecs[i].io,
              vecs[i].ro, vecs[i].mir, vecs[i].hit, vecs[i].idx);
    end
    @(negedge clk);
    addr_valid = 1'b0;
    sample();
    chk("dec_valid_low", {63'd0, dec_valid}, 64'd0);

    // Write protect on the default map (misses resolve readonly).
    drive_addr(17'h0F000, 1'b1); sample();
    chk_fault("wp_first", 1'b1, 17'h0F000, 8'd1);
    drive_addr(17'h0D000, 1'b1); sample();
    chk_fault("wp_second", 1'b1, 17'h0F000, 8'd2);
    drive_addr(17'h00100, 1'b1); sample();
    chk_fault("wp_ram_write", 1'b1, 17'h0F000, 8'd2);
    drive_addr(17'h0E000, 1'b1); fault_clear = 1'b1; sample();
    chk_fault("wp_clear_event", 1'b1, 17'h0E000, 8'd1);
    @(negedge clk); addr_valid = 1'b0; addr_we = 1'b0; sample();
    chk_fault("wp_clear", 1'b0, 17'h0, 8'd0);
    drive_addr(17'h0F000, 1'b1); fault_clear = 1'b0;
    repeat (300) @(posedge clk);
    #1;
    chk_fault("wp_saturate", 1'b1, 17'h0F000, 8'd255);
    @(negedge clk); addr_valid = 1'b0; addr_we = 1'b0; fault_clear = 1'b1;
    sample();
    @(negedge clk); fault_clear = 1'b0;

    // Atomic commit: staged entries stay invisible until committed.
    for (int k = 0; k < 4; k++) begin
      drive_addr(probe[k], 1'b0);
      set_cfg(3'(k), stage_base[k], 17'h1F000, stage_attr[k], 1'b0);
      sample();
      clr_cfg();
      if (k == 2) chk_dec("stage_e815", 6'b000100, 1'b1, 1'b0, 1'b0, 1'b1, 3'd3);
      else        chk_miss($sformatf("stage_%0h", probe[k]));
    end
    drive_addr(17'h0C000, 1'b0); cfg_commit = 1'b1; sample();
    cfg_commit = 1'b0;
    chk_miss("commit_cycle_old");
    drive_addr(17'h0C000, 1'b0); sample();
    chk_dec("new_c000", 6'b000100, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0);
    drive_addr(17'h0D000, 1'b0); sample();
    chk_dec("new_d000", 6'b001000, 1'b1, 1'b0, 1'b0, 1'b1, 3'd1);
    drive_addr(17'h0E815, 1'b0); sample();
    chk_dec("new_e815", 6'b010000, 1'b0, 1'b1, 1'b0, 1'b1, 3'd2);
    drive_addr(17'h0F000, 1'b0); sample();
    chk_dec("new_f000", 6'b100000, 1'b0, 1'b0, 1'b1, 1'b1, 3'd3);

    // Priority: a wide entry 0 overrides entry 1.
    drive_addr(17'h08000, 1'b0);
    set_cfg(3'd1, 17'h08000, 17'h1F000, mk_attr(6'b000001, 1'b0, 1'b0, 1'b1), 1'b1);
    sample();
    chk_miss("prio_before");
    drive_addr(17'h08000, 1'b0);
    set_cfg(3'd0, 17'h00000, 17'h10000, mk_attr(6'b000010, 1'b0, 1'b0, 1'b0), 1'b1);
    sample();
    clr_cfg();
    chk_dec("prio_entry1", 6'b000001, 1'b0, 1'b0, 1'b1, 1'b1, 3'd1);
    drive_addr(17'h08000, 1'b0); sample();
    chk_dec("prio_entry0", 6'b000010, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0);

    // Async reset while a shadow write is staged.
    drive_addr(17'h00123, 1'b0);
    set_cfg(3'd0, 17'h00000, 17'h1F000, mk_attr(6'b001000, 1'b0, 1'b0, 1'b0), 1'b0);
    sample();
    clr_cfg();
    chk_dec("pre_reset", 6'b000010, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0);
    #2;
    reset_n = 1'b0;
    #1;
    chk_all_zero("async_reset");
    @(negedge clk);
    reset_n = 1'b1; cfg_commit = 1'b1; addr = 17'h00010; addr_valid = 1'b1; addr_we = 1'b0;
    sample();
    cfg_commit = 1'b0;
    chk_dec("post_reset_ram", 6'b000001, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0);
    drive_addr(17'h00010, 1'b0); sample();
    chk_dec("staged_lost", 6'b000001, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0);

    // Same-cycle write and commit on entry 7.
    drive_addr(17'h0E905, 1'b0);
    set_cfg(3'd7, 17'h0E900, 17'h1FF00, mk_attr(6'b010000, 1'b1, 1'b0, 1'b0), 1'b1);
    sample();
    clr_cfg();
    chk_miss("e7_commit_cycle");
    drive_addr(17'h0E905, 1'b0); sample();
    chk_dec("e7_hit", 6'b010000, 1'b1, 1'b0, 1'b0, 1'b1, 3'd7);

    @(negedge clk);
    addr_valid = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
